// File: rtl/interboard_tx_if.sv
// Control and link signals of the inter-board serial transmitter.
//   master : the side that issues messages and models the remote ack
//            (drives ctrl_*, transmit, rx_ack)
//   slave  : the transmitter itself (drives tx_*, inter_ready, status flags)
interface interboard_tx_if;
  logic       ctrl_en;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;
  logic       transmit;
  logic       rx_ack;
  logic       tx_frame;
  logic       tx_data;
  logic       tx_req;
  logic       inter_ready;
  logic       busy;
  logic       link_err;
  logic       overrun;

  modport master (
    output ctrl_en, ctrl_msg_type, ctrl_number, transmit, rx_ack,
    input  tx_frame, tx_data, tx_req, inter_ready, busy, link_err, overrun
  );

  modport slave (
    input  ctrl_en, ctrl_msg_type, ctrl_number, transmit, rx_ack,
    output tx_frame, tx_data, tx_req, inter_ready, busy, link_err, overrun
  );
endinterface

// File: rtl/interboard_tx.sv
// interboard_tx: sends one 9-bit control frame ({type, number, odd parity},
// MSB first) bit-serially over a 4-phase req/ack link to the other board and
// pulses inter_ready once the last bit has been acknowledged.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   bus  - interboard_tx_if.slave: ctrl_en/ctrl_msg_type/ctrl_number/transmit
//          in, rx_ack in (async), tx_frame/tx_data/tx_req out (registered),
//          inter_ready pulse, busy, sticky link_err and overrun flags.
module interboard_tx #(
  parameter int SETUP_CYCLES = 4,
  parameter int TIMEOUT      = 50000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  interboard_tx_if.slave  bus
);

  localparam int TMAX = (TIMEOUT > SETUP_CYCLES) ? TIMEOUT : SETUP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, REQ_LO, DONE, ERR} state_t;

  state_t                 state;
  logic [8:0]             shift;
  logic [3:0]             bit_cnt;
  logic [TW-1:0]          timer;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;

  logic tx_frame_q, tx_data_q, tx_req_q, inter_ready_q;
  logic busy_q, link_err_q, overrun_q;

  logic [7:0] msg;
  logic [8:0] frame_w;
  logic       busy_st;

  assign msg     = {bus.ctrl_msg_type, bus.ctrl_number};
  assign frame_w = {msg, ~^msg};
  assign ack_s   = ack_sync[SYNC_STAGES-1];
  // DONE still counts as busy so a strobe landing on the ready pulse is flagged.
  assign busy_st = (state == SETUP) || (state == REQ_HI) ||
                   (state == REQ_LO) || (state == DONE);

  // rx_ack comes from another board's clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_sync <= '0;
    else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.rx_ack};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      timer         <= '0;
      tx_frame_q    <= 1'b0;
      tx_data_q     <= 1'b0;
      tx_req_q      <= 1'b0;
      inter_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      link_err_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      inter_ready_q <= 1'b0;
      if (bus.ctrl_en && busy_st) overrun_q <= 1'b1;

      case (state)
        IDLE, ERR: begin
          if (bus.ctrl_en && bus.transmit) begin
            state      <= SETUP;
            shift      <= frame_w;
            bit_cnt    <= '0;
            timer      <= '0;
            tx_frame_q <= 1'b1;
            tx_data_q  <= frame_w[8];
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        // tx_data has been stable since entry; raise req after the setup time.
        SETUP: begin
          if (timer == TW'(SETUP_CYCLES - 1)) begin
            state    <= REQ_HI;
            tx_req_q <= 1'b1;
            timer    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        REQ_HI: begin
          if (ack_s) begin
            state    <= REQ_LO;
            tx_req_q <= 1'b0;
            timer    <= '0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state      <= ERR;
            tx_req_q   <= 1'b0;
            tx_frame_q <= 1'b0;
            tx_data_q  <= 1'b0;
            busy_q     <= 1'b0;
            link_err_q <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // Wait for the remote to release ack before moving to the next bit.
        REQ_LO: begin
          if (!ack_s) begin
            timer <= '0;
            if (bit_cnt == 4'd8) begin
              state         <= DONE;
              inter_ready_q <= 1'b1;
              tx_frame_q    <= 1'b0;
              tx_data_q     <= 1'b0;
            end else begin
              state     <= SETUP;
              shift     <= {shift[7:0], 1'b0};
              tx_data_q <= shift[7];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state      <= ERR;
            tx_req_q   <= 1'b0;
            tx_frame_q <= 1'b0;
            tx_data_q  <= 1'b0;
            busy_q     <= 1'b0;
            link_err_q <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          timer  <= '0;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          timer  <= '0;
        end
      endcase
    end
  end

  assign bus.tx_frame    = tx_frame_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_req      = tx_req_q;
  assign bus.inter_ready = inter_ready_q;
  assign bus.busy        = busy_q;
  assign bus.link_err    = link_err_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_interboard_tx.sv
// Directed bench for interboard_tx: a remote-board responder echoes tx_req
// on rx_ack, a monitor rebuilds each frame from tx_data at rising tx_req and
// checks it against a scoreboard queue filled when a message is issued.
module tb_interboard_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  interboard_tx_if bus();

  interboard_tx #(.SETUP_CYCLES(4), .TIMEOUT(100), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total  = 0;
  int         bad    = 0;
  int         ir_cnt = 0;
  int         nbits  = 0;
  int         cyc    = 0;
  int         t0, t1;
  logic [8:0] q[$];
  logic [8:0] cap    = '0;
  logic [8:0] exp_f;
  logic       cur_bit = 1'b0;
  logic       prev_req = 1'b0;
  logic       seen;
  bit         ack_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Remote board: acks follow req (zero remote delay) when enabled.
  initial forever begin
    @(negedge clk);
    bus.rx_ack = ack_en & bus.tx_req;
  end

  // Frame monitor / scoreboard consumer.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      nbits = 0; cap = '0; prev_req = 1'b0;
    end else begin
      if (bus.tx_req && !prev_req) begin
        cur_bit = bus.tx_data;
        cap     = {cap[7:0], bus.tx_data};
        nbits++;
      end else if (bus.tx_req) begin
        chk("data_stable", 32'(bus.tx_data), 32'(cur_bit));
      end
      if (bus.inter_ready) begin
        ir_cnt++;
        chk("sb_pending", 32'(q.size() > 0), 32'(1));
        if (q.size() > 0) begin
          exp_f = q.pop_front();
          chk("frame", 32'(cap), 32'(exp_f));
          chk("nbits", 32'(nbits), 32'(9));
        end
        nbits = 0; cap = '0;
      end else if (!bus.tx_frame) begin
        nbits = 0; cap = '0;
      end
      prev_req = bus.tx_req;
    end
  end

  task automatic send(input logic [2:0] t, input logic [4:0] n, input logic [8:0] e);
    @(negedge clk);
    bus.ctrl_en = 1'b1; bus.ctrl_msg_type = t; bus.ctrl_number = n; bus.transmit = 1'b1;
    q.push_back(e);
    @(negedge clk);
    bus.ctrl_en = 1'b0;
    chk("latency_frame", 32'(bus.tx_frame), 32'(1));
    chk("latency_busy", 32'(bus.busy), 32'(1));
  endtask

  task automatic wait_ir(input int n, input int max);
    for (int i = 0; i < max && ir_cnt < n; i++) @(negedge clk);
    chk("ready_timeout", 32'(ir_cnt >= n), 32'(1));
  endtask

  initial begin
    bus.ctrl_en = 1'b0; bus.ctrl_msg_type = '0; bus.ctrl_number = '0;
    bus.transmit = 1'b0; bus.rx_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({bus.tx_frame, bus.tx_data, bus.tx_req, bus.inter_ready,
                           bus.busy, bus.link_err, bus.overrun}), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'(0));

    // ctrl_en without transmit is ignored
    bus.ctrl_en = 1'b1; bus.transmit = 1'b0; bus.ctrl_msg_type = 3'd3; bus.ctrl_number = 5'd5;
    @(negedge clk);
    bus.ctrl_en = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen = seen | bus.tx_frame | bus.busy; end
    chk("no_transmit_idle", 32'(seen), 32'(0));
    chk("no_transmit_ovr", 32'(bus.overrun), 32'(0));

    // type 010, num 17 -> 0,1,0,1,0,0,0,1,0
    ack_en = 1'b1;
    send(3'b010, 5'd17, 9'b010100010);
    wait_ir(1, 400);
    repeat (20) @(negedge clk);
    chk("t1_once", 32'(ir_cnt), 32'(1));
    chk("t1_idle", 32'(bus.busy), 32'(0));

    // type 111, num 25 -> data F9, parity 1
    send(3'b111, 5'd25, 9'b111110011);
    wait_ir(2, 400);

    // second ctrl_en during bit 4
    send(3'b001, 5'd9, 9'b001010010);
    for (int i = 0; i < 300 && nbits < 5; i++) @(negedge clk);
    chk("t3_reach_bit4", 32'(nbits >= 5), 32'(1));
    bus.ctrl_en = 1'b1; bus.ctrl_msg_type = 3'd7; bus.ctrl_number = 5'd3;
    @(negedge clk);
    bus.ctrl_en = 1'b0;
    chk("t3_overrun", 32'(bus.overrun), 32'(1));
    wait_ir(3, 400);
    repeat (20) @(negedge clk);
    chk("t3_one_ready", 32'(ir_cnt), 32'(3));
    chk("t3_no_second", 32'(bus.tx_frame), 32'(0));
    chk("t3_sb_empty", 32'(q.size()), 32'(0));

    // reset during REQ_HI
    ack_en = 1'b0;
    send(3'b100, 5'd2, 9'b100000101);
    for (int i = 0; i < 50 && !bus.tx_req; i++) @(negedge clk);
    chk("t5_in_req_hi", 32'(bus.tx_req), 32'(1));
    rst = 1'b0;
    #1;
    chk("t5_async_clear", 32'({bus.tx_frame, bus.tx_data, bus.tx_req, bus.inter_ready,
                               bus.busy, bus.link_err, bus.overrun}), 32'(0));
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1; ack_en = 1'b1;
    @(negedge clk);
    chk("t5_idle", 32'(bus.busy), 32'(0));
    send(3'b100, 5'd2, 9'b100000101);
    wait_ir(4, 400);

    // ack timeout -> ERR, then restart
    ack_en = 1'b0;
    send(3'b011, 5'd20, 9'b011101001);
    t0 = cyc;
    for (int i = 0; i < 50 && !bus.tx_req; i++) @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 300 && !bus.link_err; i++) @(negedge clk);
    t1 = cyc;
    chk("t2_link_err", 32'(bus.link_err), 32'(1));
    chk("t2_err_time", 32'((t1 - t0) >= 98 && (t1 - t0) <= 102), 32'(1));
    chk("t2_outs_low", 32'({bus.tx_frame, bus.tx_req, bus.busy}), 32'(0));
    repeat (5) @(negedge clk);
    chk("t2_no_ready", 32'(ir_cnt), 32'(4));
    q.delete();
    ack_en = 1'b1;
    send(3'b011, 5'd20, 9'b011101001);
    wait_ir(5, 400);
    chk("t2_err_sticky", 32'(bus.link_err), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
